instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the accumulator computer: reads 16-bit instructions from the byte-addressed main memory (big-endian, two byte reads per instruction) at the program counter and presents them, with their address, to the control/decode stage over a valid/ready handshake. Owns the PC: increments it by 2 per fetched instruction and accepts a redirect (jump/branch/skip) from control. Sits between `MainMemory` (read port) and the control unit's instruction-register load.

## Interface
- `ADDR_WIDTH`, 14: memory address width; PC wraps modulo 2^ADDR_WIDTH.
- `RESET_PC`, 0: PC value after reset; must be even.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high allows a new fetch to start; low stalls in IDLE.
- `mem_read_en`  out  1  read strobe to main memory.
- `mem_addr`  out  16  byte address; upper bits above ADDR_WIDTH driven 0.
- `mem_rdata`  in  8  read byte, valid the cycle after `mem_read_en`.
- `instr`  out  16  fetched instruction; [15:12] opcode, [11:0] operand address.
- `instr_pc`  out  16  byte address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid instruction.
- `instr_ready`  in  1  control accepts the instruction.
- `redirect_valid`  in  1  control requests a fetch restart.
- `redirect_pc`  in  16  new PC; bit 0 ignored (forced even), masked to ADDR_WIDTH.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, FETCH_HI, FETCH_LO, WAIT_LO, HOLD.
- IDLE: `enable`=1 -> FETCH_HI; else stay.
- FETCH_HI: `mem_read_en`=1, `mem_addr`=pc -> FETCH_LO.
- FETCH_LO: `mem_read_en`=1, `mem_addr`=pc+1; capture `mem_rdata` into `instr[15:8]` -> WAIT_LO.
- WAIT_LO: capture `mem_rdata` into `instr[7:0]`; `instr_pc`<=pc; pc<=pc+2 (mod 2^ADDR_WIDTH) -> HOLD.
- HOLD: `instr_valid`=1; outputs stable until transfer. Transfer = `instr_valid & instr_ready & ~redirect_valid`. On transfer: `enable` ? FETCH_HI : IDLE.
- Redirect (any state): pc<=redirect_pc (bit 0 cleared, masked); any in-flight read data discarded; held instruction discarded (no transfer); `instr_valid` low next cycle; next state FETCH_HI if `enable`, else IDLE. Redirect has priority over transfer and over the normal transition.
- `enable` low mid-fetch: current instruction completes to HOLD; no new fetch started after transfer.
- PC wrap: pc = 2^ADDR_WIDTH-2 fetches bytes at 16382/16383, then pc wraps to 0.
- Reset mid-operation: immediate return to IDLE with reset values; in-flight read ignored.

## Timing
- Reset values: state IDLE, pc=RESET_PC, `mem_read_en`=0, `mem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0.
- Latency: FETCH_HI in cycle N -> `instr_valid` high in cycle N+3.
- Throughput with `instr_ready` tied high: one instruction per 4 cycles.
- All outputs registered or decoded from registered state only; no combinational path from `instr_ready`/`redirect_*` to outputs.
- Redirect in cycle N -> FETCH_HI (read of redirect_pc) in cycle N+1.

## Structure
- Shared package: state enum, `ADDR_WIDTH` default, opcode field bounds (15:12) and operand field bounds (11:0), `INSTR_BYTES`=2.
- Single module, no sub-modules; PC counter and byte-assembly register inline.

## Test plan
- Reset, RESET_PC=0, mem[0..3]=8'h12,8'h34,8'hAB,8'hCD, `enable`=1, ready high -> `instr`=16'h1234/`instr_pc`=0 at cycle 3, 16'hABCD/`instr_pc`=2 at cycle 7.
- Backpressure: ready low 5 cycles in HOLD -> `instr`=16'h1234 stable, no memory reads; ready high -> single transfer, next fetch at addr 2.
- Redirect to 16'h0101 during FETCH_LO -> next read at addr 0x0100, discarded byte never appears; `instr_pc`=0x0100.
- Redirect and ready same cycle in HOLD -> no transfer counted, next `instr_pc` = redirect target.
- Wrap: redirect to 16382, mem[16382..16383]=8'h9F,8'h00 -> `instr`=16'h9F00, `instr_pc`=16382, following fetch at addr 0.
- `reset_n` low asynchronously in WAIT_LO -> outputs at reset values immediately; after release with `enable`=0, stays IDLE, `busy`=0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage of the accumulator computer.
package instruction_fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 14;
    localparam int unsigned MEM_ADDR_WIDTH     = 16;
    localparam int unsigned INSTR_WIDTH        = 16;
    localparam int unsigned BYTE_WIDTH         = 8;
    localparam int unsigned INSTR_BYTES        = 2;

    localparam int unsigned OPCODE_MSB  = 15;
    localparam int unsigned OPCODE_LSB  = 12;
    localparam int unsigned OPERAND_MSB = 11;
    localparam int unsigned OPERAND_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        WAIT_LO,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [OPCODE_MSB-OPCODE_LSB:0]   opcode;
        logic [OPERAND_MSB-OPERAND_LSB:0] operand;
    } instr_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: reads big-endian 16-bit instructions two bytes at a time at the PC
// and offers them to control over a valid/ready handshake; owns the PC and redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    output logic                      mem_read_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [BYTE_WIDTH-1:0]     mem_rdata,
    output logic [INSTR_WIDTH-1:0]    instr,
    output logic [MEM_ADDR_WIDTH-1:0] instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      redirect_valid,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc,
    output logic                      busy
);

    localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC) & ~ADDR_WIDTH'(1);

    fetch_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [BYTE_WIDTH-1:0]       hi_q, hi_d;
    instr_t                      instr_q, instr_d;
    logic [MEM_ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                        read_en_q, read_en_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]       redirect_target;
    logic                        unused_redirect_bits;

    // Redirect target is forced even and folded into the PC's address space.
    assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
    assign unused_redirect_bits = ^redirect_pc;

    // Next-state, PC, byte assembly and next registered output values.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hi_d       = hi_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            IDLE:     if (enable) state_d = FETCH_HI;
            FETCH_HI: state_d = FETCH_LO;
            FETCH_LO: begin
                hi_d    = mem_rdata;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                instr_d    = instr_t'({hi_q, mem_rdata});
                instr_pc_d = MEM_ADDR_WIDTH'(pc_q);
                pc_d       = pc_q + ADDR_WIDTH'(INSTR_BYTES);
                state_d    = HOLD;
            end
            HOLD:     if (instr_ready) state_d = enable ? FETCH_HI : IDLE;
            default:  state_d = IDLE;
        endcase

        // Redirect wins over transfer and discards any partially assembled instruction.
        if (redirect_valid) begin
            pc_d       = redirect_target;
            hi_d       = hi_q;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            state_d    = enable ? FETCH_HI : IDLE;
        end

        read_en_d = (state_d == FETCH_HI) || (state_d == FETCH_LO);
        valid_d   = (state_d == HOLD);
        busy_d    = (state_d != IDLE);
        case (state_d)
            FETCH_HI: addr_d = MEM_ADDR_WIDTH'(pc_d);
            FETCH_LO: addr_d = MEM_ADDR_WIDTH'(pc_d + ADDR_WIDTH'(1));
            default:  addr_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            hi_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            read_en_q  <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hi_q       <= hi_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            read_en_q  <= read_en_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_read_en = read_en_q;
    assign mem_addr    = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency byte memory model.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        mem_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        busy;

    logic [7:0]  mem [0:16383];
    int          n_cmp;
    int          n_bad;

    instruction_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_read_en) mem_rdata <= mem[mem_addr[13:0]];
    end

    task automatic do_reset();
        reset_n        = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Bounded wait for instr_valid; returns cycles waited, or 99 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!instr_valid && cycles < 20);
        if (!instr_valid) cycles = 99;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({mem_read_en, mem_addr, instr, instr_pc, instr_valid, busy} !== 51'd0) begin
            n_bad++;
            $display("FAIL reset_values: got rd=%b addr=%h instr=%h pc=%h v=%b busy=%b want all 0",
                     mem_read_en, mem_addr, instr, instr_pc, instr_valid, busy);
        end
    endtask

    task automatic test_basic();
        int k;
        int lat;
        do_reset();
        enable      = 1'b1;
        instr_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!mem_read_en && k < 10);
        n_cmp++;
        if (mem_addr !== 16'h0000 || mem_read_en !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_first_read: got rd=%b addr=%h want 1/0000", mem_read_en, mem_addr);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (instr !== 16'h1234 || instr_pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL basic_instr0: got %h@%h want 1234@0000", instr, instr_pc);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL basic_throughput: got %0d want 4", lat);
        end
        n_cmp++;
        if (instr !== 16'hABCD || instr_pc !== 16'h0002) begin
            n_bad++;
            $display("FAIL basic_instr1: got %h@%h want abcd@0002", instr, instr_pc);
        end
    endtask

    task automatic test_backpressure();
        int  lat;
        logic held_ok;
        do_reset();
        enable = 1'b1;
        wait_valid(lat);
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (instr_valid !== 1'b1 || instr !== 16'h1234 || mem_read_en !== 1'b0)
                held_ok = 1'b0;
        end
        n_cmp++;
        if (held_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold_stable: got v=%b instr=%h rd=%b want 1/1234/0",
                     instr_valid, instr, mem_read_en);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_read_en !== 1'b1 || mem_addr !== 16'h0002) begin
            n_bad++;
            $display("FAIL bp_next_fetch: got v=%b rd=%b addr=%h want 0/1/0002",
                     instr_valid, mem_read_en, mem_addr);
        end
        wait_valid(lat);
        n_cmp++;
        if (instr !== 16'hABCD || instr_pc !== 16'h0002) begin
            n_bad++;
            $display("FAIL bp_single_transfer: got %h@%h want abcd@0002", instr, instr_pc);
        end
    endtask

    task automatic test_redirect_fetch_lo();
        int k;
        int lat;
        do_reset();
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(mem_read_en && mem_addr == 16'h0001) && k < 10);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0101;
        @(negedge clock);
        redirect_valid = 1'b0;
        n_cmp++;
        if (mem_read_en !== 1'b1 || mem_addr !== 16'h0100) begin
            n_bad++;
            $display("FAIL redir_lo_read: got rd=%b addr=%h want 1/0100", mem_read_en, mem_addr);
        end
        wait_valid(lat);
        n_cmp++;
        if (instr !== 16'h5AC3 || instr_pc !== 16'h0100) begin
            n_bad++;
            $display("FAIL redir_lo_instr: got %h@%h want 5ac3@0100", instr, instr_pc);
        end
    endtask

    task automatic test_redirect_hold();
        int lat;
        do_reset();
        enable = 1'b1;
        wait_valid(lat);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        @(negedge clock);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_addr !== 16'h0100) begin
            n_bad++;
            $display("FAIL redir_hold_next: got v=%b addr=%h want 0/0100", instr_valid, mem_addr);
        end
        wait_valid(lat);
        n_cmp++;
        if (instr_pc !== 16'h0100 || instr !== 16'h5AC3) begin
            n_bad++;
            $display("FAIL redir_hold_instr: got %h@%h want 5ac3@0100", instr, instr_pc);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        enable         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd16382;
        @(negedge clock);
        redirect_valid = 1'b0;
        n_cmp++;
        if (mem_read_en !== 1'b1 || mem_addr !== 16'd16382) begin
            n_bad++;
            $display("FAIL wrap_hi_addr: got rd=%b addr=%0d want 1/16382", mem_read_en, mem_addr);
        end
        @(negedge clock);
        n_cmp++;
        if (mem_addr !== 16'd16383) begin
            n_bad++;
            $display("FAIL wrap_lo_addr: got %0d want 16383", mem_addr);
        end
        wait_valid(lat);
        n_cmp++;
        if (instr !== 16'h9F00 || instr_pc !== 16'd16382) begin
            n_bad++;
            $display("FAIL wrap_instr: got %h@%0d want 9f00@16382", instr, instr_pc);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
        n_cmp++;
        if (mem_read_en !== 1'b1 || mem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_next_addr: got rd=%b addr=%h want 1/0000", mem_read_en, mem_addr);
        end
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(mem_read_en && mem_addr == 16'h0001) && k < 10);
        @(negedge clock);
        n_cmp++;
        if (busy !== 1'b1 || mem_read_en !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ares_in_wait_lo: got busy=%b rd=%b v=%b want 1/0/0",
                     busy, mem_read_en, instr_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_read_en, mem_addr, instr, instr_pc, instr_valid, busy} !== 51'd0) begin
            n_bad++;
            $display("FAIL ares_immediate: got rd=%b addr=%h instr=%h pc=%h v=%b busy=%b want all 0",
                     mem_read_en, mem_addr, instr, instr_pc, instr_valid, busy);
        end
        enable = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b0 || mem_read_en !== 1'b0 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ares_idle_after: got busy=%b rd=%b v=%b want 0/0/0",
                     busy, mem_read_en, instr_valid);
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset_n        = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        mem_rdata      = 8'h00;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[0]     = 8'h12;
        mem[1]     = 8'h34;
        mem[2]     = 8'hAB;
        mem[3]     = 8'hCD;
        mem[16'h100] = 8'h5A;
        mem[16'h101] = 8'hC3;
        mem[16382] = 8'h9F;
        mem[16383] = 8'h00;

        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_fetch_lo();
        test_redirect_hold();
        test_wrap();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
